// File: rtl/output_port_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : output_port_tx
// Purpose  : Transmit side of one router output link. Round-robin arbitration
//            among the local input queues, wormhole packet locking, and a
//            2-entry output FIFO feeding the downstream valid/en handshake.
// Ports    : clk, rst       - clock, asynchronous active-high reset
//            req_i          - per-queue request (non-empty, routed here)
//            flit_i         - head flit of each FWFT queue, queue i at
//                             [i*DATA_W +: DATA_W]
//            pop_req_o      - one-hot-or-zero pop back to the queues
//            data_o/valid_o - flit and valid toward the downstream buffer
//            en_i           - downstream buffer accepts a flit this cycle
//            busy_o         - a packet currently owns the link
// Revision : 1.0 - initial release
// ============================================================================
module output_port_tx #(
  parameter int DATA_W = 32,
  parameter int NPORT  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NPORT-1:0]        req_i,
  input  logic [NPORT*DATA_W-1:0] flit_i,
  output logic [NPORT-1:0]        pop_req_o,
  output logic [DATA_W-1:0]       data_o,
  output logic                    valid_o,
  input  logic                    en_i,
  output logic                    busy_o
);

  localparam int c_PTR_W = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(NPORT - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_PTR_W-1:0]   r_owner;
  logic [c_PTR_W-1:0]   w_owner_nxt;
  logic [c_PTR_W-1:0]   r_ptr;
  logic [c_PTR_W-1:0]   w_ptr_nxt;
  logic [c_PTR_W-1:0]   w_grant;
  logic [c_PTR_W-1:0]   w_sel;
  logic                 w_grant_vld;
  logic [NPORT-1:0]     w_elig;
  logic [NPORT-1:0]     w_pop;
  logic [DATA_W-1:0]    w_sel_flit;
  logic [1:0]           w_sel_type;
  logic                 w_space;
  logic                 w_xfer;
  logic                 w_push;

  logic [DATA_W-1:0]    r_mem [2];
  logic                 r_rd;
  logic                 r_wr;
  logic [1:0]           r_count;

  function automatic logic [c_PTR_W-1:0] f_inc(input logic [c_PTR_W-1:0] v);
    f_inc = (v == c_LAST) ? '0 : v + 1'b1;
  endfunction

  // A queue may open a packet only if its head flit is head (10) or single
  // (11): both have the type MSB set.
  for (genvar gi = 0; gi < NPORT; gi++) begin : g_elig
    assign w_elig[gi] = req_i[gi] & flit_i[gi*DATA_W + DATA_W - 1];
  end

  // Round-robin search starting at the pointer, wrapping modulo NPORT.
  always_comb begin : p_arb
    int idx;
    idx         = 0;
    w_grant_vld = 1'b0;
    w_grant     = '0;
    for (int k = 0; k < NPORT; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NPORT) idx = idx - NPORT;
      if (!w_grant_vld && w_elig[idx[c_PTR_W-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant     = idx[c_PTR_W-1:0];
      end
    end
  end

  // Link handshake and FIFO space. A full FIFO still accepts a push in the
  // same cycle that its head leaves on the link.
  assign valid_o = (r_count != 2'd0);
  assign data_o  = r_mem[r_rd];
  assign busy_o  = (r_state == S_LOCKED);
  assign w_xfer  = valid_o & en_i;
  assign w_space = (r_count != 2'd2) | w_xfer;

  // While locked only the owner's queue is ever looked at.
  assign w_sel      = (r_state == S_LOCKED) ? r_owner : w_grant;
  assign w_sel_flit = flit_i[w_sel*DATA_W +: DATA_W];
  assign w_sel_type = w_sel_flit[DATA_W-1 -: 2];

  always_comb begin : p_fsm
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_pop       = '0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_vld && w_space) begin
          w_pop[w_grant] = 1'b1;
          // Type LSB set means the packet ends with this flit (single).
          if (w_sel_type[0]) begin
            w_ptr_nxt = f_inc(w_grant);
          end else begin
            w_state_nxt = S_LOCKED;
            w_owner_nxt = w_grant;
          end
        end
      end
      S_LOCKED: begin
        // An empty owner queue is a bubble: the lock is kept.
        if (req_i[r_owner] && w_space) begin
          w_pop[r_owner] = 1'b1;
          if (w_sel_type[0]) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = f_inc(r_owner);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Pops must vanish the moment reset is asserted, not at the next edge.
  assign pop_req_o = rst ? '0 : w_pop;
  assign w_push    = |w_pop;

  always_ff @(posedge clk or posedge rst) begin : p_state
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin : p_fifo
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= w_sel_flit;
        r_wr        <= ~r_wr;
      end
      if (w_xfer) begin
        r_rd <= ~r_rd;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_xfer};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_output_port_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_output_port_tx
// Purpose  : Self-checking bench for output_port_tx. Five FWFT queue models
//            feed the DUT; expected link flits are queued in a scoreboard
//            as stimulus is loaded and compared as they leave on the link.
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_port_tx;

  localparam int DW = 32;
  localparam int NP = 5;
  localparam logic [1:0] T_HEAD = 2'b10;
  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b01;
  localparam logic [1:0] T_SGL  = 2'b11;

  logic             clk;
  logic             rst;
  logic [NP-1:0]    req_i;
  logic [NP*DW-1:0] flit_i;
  logic [NP-1:0]    pop_req_o;
  logic [DW-1:0]    data_o;
  logic             valid_o;
  logic             en_i;
  logic             busy_o;

  output_port_tx #(.DATA_W(DW), .NPORT(NP)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .flit_i    (flit_i),
    .pop_req_o (pop_req_o),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .en_i      (en_i),
    .busy_o    (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  string         tag    = "init";
  logic [DW-1:0] envq [NP][$];
  logic [DW-1:0] sb [$];
  logic          stalled_prev;

  typedef struct {
    logic [NP-1:0]    req;
    logic [NP*DW-1:0] flits;
    logic [NP-1:0]    exp_pop;
    logic             exp_valid;
    logic [DW-1:0]    exp_data;
    logic             exp_busy;
  } vec_t;

  vec_t vecs [8];
  int   rr_pop [5] = '{1, 4, 16, 1, 4};

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input logic [29:0] p);
    return {t, p};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s/%s actual=%h required=%h", tag, name, act, req_v);
    end
  endtask

  task automatic load(input int port, input logic [DW-1:0] f);
    envq[port].push_back(f);
    sb.push_back(f);
  endtask

  task automatic drive_env;
    for (int i = 0; i < NP; i++) begin
      if (envq[i].size() != 0) begin
        req_i[i]            = 1'b1;
        flit_i[i*DW +: DW]  = envq[i][0];
      end else begin
        req_i[i]            = 1'b0;
        flit_i[i*DW +: DW]  = '0;
      end
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    for (int i = 0; i < NP; i++) envq[i].delete();
    sb.delete();
    req_i        = '0;
    flit_i       = '0;
    en_i         = 1'b1;
    stalled_prev = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_pop", 32'(pop_req_o), 32'd0);
  endtask

  // One clock cycle: drive inputs, sample at the falling edge, let the
  // environment consume popped flits just after the rising edge.
  // Negative expectation values mean "not checked".
  task automatic step(input logic en, input int exp_pop, input int exp_busy, input int exp_valid);
    logic [NP-1:0] pop_seen;
    en_i = en;
    drive_env();
    @(negedge clk);
    if (exp_pop >= 0)   chk("pop", 32'(pop_req_o), 32'(exp_pop));
    if (exp_busy >= 0)  chk("busy", 32'(busy_o), 32'(exp_busy));
    if (exp_valid >= 0) chk("valid", 32'(valid_o), 32'(exp_valid));
    if (stalled_prev)   chk("valid_hold", 32'(valid_o), 32'd1);
    if (valid_o && en_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s/extra_flit actual=%h required=none", tag, data_o);
      end else begin
        chk("link_data", data_o, sb.pop_front());
      end
    end
    stalled_prev = valid_o && !en_i;
    pop_seen     = pop_req_o;
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (pop_seen[i]) begin
        if (envq[i].size() != 0) begin
          void'(envq[i].pop_front());
        end else begin
          checks++;
          errors++;
          $display("FAIL %s/pop_empty actual=port%0d required=no_pop", tag, i);
        end
      end
    end
  endtask

  task automatic drain;
    for (int k = 0; k < 20 && sb.size() != 0; k++) step(1'b1, -1, -1, -1);
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    req_i  = '0;
    flit_i = '0;
    en_i   = 1'b1;

    // IDLE arbitration from reset (pointer at north, FIFO empty).
    vecs[0] = '{5'b00001, {mk(T_HEAD,30'h4), mk(T_HEAD,30'h3), mk(T_HEAD,30'h2), mk(T_HEAD,30'h1), mk(T_SGL,30'h1)},
                5'b00001, 1'b1, 32'hC000_0001, 1'b0};
    vecs[1] = '{5'b00110, {mk(T_SGL,30'h4), mk(T_SGL,30'h3), mk(T_HEAD,30'h22), mk(T_BODY,30'h11), mk(T_SGL,30'h0)},
                5'b00100, 1'b1, mk(T_HEAD,30'h22), 1'b1};
    vecs[2] = '{5'b11000, {mk(T_SGL,30'h44), mk(T_TAIL,30'h33), mk(T_SGL,30'h2), mk(T_SGL,30'h1), mk(T_SGL,30'h0)},
                5'b10000, 1'b1, mk(T_SGL,30'h44), 1'b0};
    vecs[3] = '{5'b00000, {mk(T_HEAD,30'h4), mk(T_HEAD,30'h3), mk(T_HEAD,30'h2), mk(T_HEAD,30'h1), mk(T_HEAD,30'h0)},
                5'b00000, 1'b0, 32'h0, 1'b0};
    vecs[4] = '{5'b00011, {mk(T_SGL,30'h4), mk(T_SGL,30'h3), mk(T_SGL,30'h2), mk(T_SGL,30'h51), mk(T_HEAD,30'h50)},
                5'b00001, 1'b1, mk(T_HEAD,30'h50), 1'b1};
    vecs[5] = '{5'b11110, {mk(T_TAIL,30'h4), mk(T_BODY,30'h3), mk(T_TAIL,30'h2), mk(T_BODY,30'h1), mk(T_SGL,30'h0)},
                5'b00000, 1'b0, 32'h0, 1'b0};
    vecs[6] = '{5'b00001, {mk(T_SGL,30'h4), mk(T_HEAD,30'h3), mk(T_SGL,30'h2), mk(T_SGL,30'h1), mk(T_BODY,30'h60)},
                5'b00000, 1'b0, 32'h0, 1'b0};
    vecs[7] = '{5'b11111, {mk(T_SGL,30'h74), mk(T_SGL,30'h73), mk(T_SGL,30'h72), mk(T_SGL,30'h71), mk(T_SGL,30'h70)},
                5'b00001, 1'b1, mk(T_SGL,30'h70), 1'b0};

    tag = "table";
    for (int v = 0; v < 8; v++) begin
      do_reset();
      req_i  = vecs[v].req;
      flit_i = vecs[v].flits;
      @(negedge clk);
      chk("tbl_pop", 32'(pop_req_o), 32'(vecs[v].exp_pop));
      @(posedge clk);
      #1;
      req_i  = '0;
      flit_i = '0;
      @(negedge clk);
      chk("tbl_valid", 32'(valid_o), 32'(vecs[v].exp_valid));
      if (vecs[v].exp_valid) chk("tbl_data", data_o, vecs[v].exp_data);
      chk("tbl_busy", 32'(busy_o), 32'(vecs[v].exp_busy));
    end

    // Single flit, then pointer must sit at south.
    tag = "single";
    do_reset();
    load(0, 32'hC000_0001);
    step(1'b1, 5'b00001, 0, 0);
    load(1, mk(T_SGL, 30'h101));
    load(0, mk(T_SGL, 30'h002));
    step(1'b1, 5'b00010, 0, 1);
    step(1'b1, 5'b00001, 0, 1);
    drain();

    // Round robin over n, e, l with no gaps on the link.
    tag = "rr";
    do_reset();
    load(0, mk(T_SGL, 30'h10));
    load(2, mk(T_SGL, 30'h20));
    load(4, mk(T_SGL, 30'h40));
    load(0, mk(T_SGL, 30'h11));
    load(2, mk(T_SGL, 30'h21));
    for (int c = 0; c < 5; c++) step(1'b1, rr_pop[c], 0, (c == 0) ? 0 : 1);
    step(1'b1, 0, 0, 1);
    drain();

    // Wormhole lock: east packet holds off west.
    tag = "worm";
    do_reset();
    load(2, mk(T_HEAD, 30'h200));
    load(2, mk(T_BODY, 30'h201));
    load(2, mk(T_BODY, 30'h202));
    load(2, mk(T_TAIL, 30'h203));
    load(3, mk(T_SGL,  30'h300));
    step(1'b1, 5'b00100, 0, 0);
    for (int c = 1; c < 4; c++) step(1'b1, 5'b00100, 1, 1);
    step(1'b1, 5'b01000, 0, 1);
    drain();

    // Backpressure on a local packet, en_i low for cycles 2..6.
    tag = "bp";
    do_reset();
    load(4, mk(T_HEAD, 30'h400));
    load(4, mk(T_BODY, 30'h401));
    load(4, mk(T_BODY, 30'h402));
    load(4, mk(T_TAIL, 30'h403));
    step(1'b1, 5'b10000, 0, 0);
    step(1'b1, 5'b10000, 1, 1);
    step(1'b0, 5'b10000, 1, 1);
    for (int c = 3; c < 7; c++) begin
      step(1'b0, 5'b00000, 1, 1);
      chk("stall_data", data_o, mk(T_BODY, 30'h401));
    end
    step(1'b1, 5'b10000, 1, 1);
    step(1'b1, 5'b00000, 0, 1);
    drain();

    // Owner bubble: north empties mid-packet while south waits.
    tag = "bubble";
    do_reset();
    envq[0].push_back(mk(T_HEAD, 30'h500));
    envq[1].push_back(mk(T_SGL,  30'h510));
    sb.push_back(mk(T_HEAD, 30'h500));
    sb.push_back(mk(T_BODY, 30'h501));
    sb.push_back(mk(T_TAIL, 30'h502));
    sb.push_back(mk(T_SGL,  30'h510));
    step(1'b1, 5'b00001, 0, 0);
    for (int c = 1; c < 4; c++) step(1'b1, 5'b00000, 1, -1);
    envq[0].push_back(mk(T_BODY, 30'h501));
    envq[0].push_back(mk(T_TAIL, 30'h502));
    step(1'b1, 5'b00001, 1, -1);
    step(1'b1, 5'b00001, 1, -1);
    step(1'b1, 5'b00010, 0, -1);
    drain();

    // Asynchronous reset between a head and its body.
    tag = "async_rst";
    do_reset();
    envq[0].push_back(mk(T_HEAD, 30'h600));
    envq[0].push_back(mk(T_BODY, 30'h601));
    step(1'b1, 5'b00001, 0, 0);
    drive_env();
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(valid_o), 32'd0);
    chk("ar_busy", 32'(busy_o), 32'd0);
    chk("ar_pop", 32'(pop_req_o), 32'd0);
    do_reset();
    load(1, mk(T_SGL, 30'h610));
    step(1'b1, 5'b00010, 0, 0);
    step(1'b1, 5'b00000, 0, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
